// File: rtl/btb_fetch.sv
// Fetch-stage next-PC unit: fetch PC register, direct-mapped BTB lookup combined
// with the PHT counter, and Execute-stage misprediction redirect / BTB training.
module btb_fetch #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned INDEX_W  = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_F,
    input  logic [1:0]  predict,
    input  logic        valid_E,
    input  logic        branch_E,
    input  logic        jump_E,
    input  logic        take_E,
    input  logic [31:0] pc_E,
    input  logic [31:0] target_E,
    input  logic        pred_taken_E,
    input  logic [31:0] pred_target_E,
    output logic [31:0] pc_F,
    output logic        btb_hit_F,
    output logic        pred_taken_F,
    output logic [31:0] pred_target_F,
    output logic        flush_E
);

    localparam int unsigned TAG_W = 32 - INDEX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jmp_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    logic [31:0]        pc_q;
    logic [31:0]        pc_d;

    logic [INDEX_W-1:0] idx_f;
    logic [TAG_W-1:0]   tag_f;
    logic [INDEX_W-1:0] idx_e;
    logic [TAG_W-1:0]   tag_e;

    logic               act_taken;
    logic [31:0]        redirect;
    logic               wr_en;
    logic               inv_en;

    assign idx_f = pc_q[INDEX_W+1:2];
    assign tag_f = pc_q[31:INDEX_W+2];
    assign idx_e = pc_E[INDEX_W+1:2];
    assign tag_e = pc_E[31:INDEX_W+2];

    // Fetch-side lookup; a jump entry is taken regardless of the counter
    assign btb_hit_F     = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pred_taken_F  = btb_hit_F && (jmp_q[idx_f] || predict[1]);
    assign pred_target_F = btb_hit_F ? tgt_q[idx_f] : 32'h0;
    assign pc_F          = pc_q;

    // Execute-side resolution; also catches aliased non-control predicted taken
    assign act_taken = jump_E || (branch_E && take_E);
    assign flush_E   = valid_E && ((act_taken != pred_taken_E) ||
                       (act_taken && pred_taken_E && (target_E != pred_target_E)));
    assign redirect  = act_taken ? target_E : pc_E + 32'd4;

    assign wr_en  = valid_E && act_taken;
    assign inv_en = valid_E && !branch_E && !jump_E && pred_taken_E;

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (flush_E) begin
            pc_d = redirect;
        end else if (stall_F) begin
            pc_d = pc_q;
        end else if (pred_taken_F) begin
            pc_d = pred_target_F;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[idx_e] <= 1'b1;
        end else if (inv_en) begin
            valid_q[idx_e] <= 1'b0;
        end
    end

    // Payload is not reset; valid gates every use of it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx_e] <= tag_e;
            tgt_q[idx_e] <= target_E;
            jmp_q[idx_e] <= jump_E;
        end
    end

endmodule

// File: tb/tb_btb_fetch.sv
// Scoreboard bench for btb_fetch: a behavioural BTB/PC model predicts each cycle's
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_btb_fetch;

    localparam int unsigned ENT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_F;
    logic [1:0]  predict;
    logic        valid_E, branch_E, jump_E, take_E, pred_taken_E;
    logic [31:0] pc_E, target_E, pred_target_E;
    logic [31:0] pc_F, pred_target_F;
    logic        btb_hit_F, pred_taken_F, flush_E;

    btb_fetch #(.ENTRIES(16), .INDEX_W(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .stall_F(stall_F), .predict(predict),
        .valid_E(valid_E), .branch_E(branch_E), .jump_E(jump_E), .take_E(take_E),
        .pc_E(pc_E), .target_E(target_E), .pred_taken_E(pred_taken_E),
        .pred_target_E(pred_target_E), .pc_F(pc_F), .btb_hit_F(btb_hit_F),
        .pred_taken_F(pred_taken_F), .pred_target_F(pred_target_F), .flush_E(flush_E)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        pt;
        logic [31:0] ptg;
        logic        fl;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 0;

    // Reference state: fetch PC plus a table of (valid, tag, target, is_jump)
    logic [31:0] m_pc;
    bit          m_v   [ENT];
    int unsigned m_tag [ENT];
    logic [31:0] m_tgt [ENT];
    bit          m_j   [ENT];

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 4) % ENT;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / (4 * ENT);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < ENT; i++) m_v[i] = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty at %0t: got 0 expected 1 entries", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pc_F", pc_F, e.pc);
                chk("btb_hit_F", 32'(btb_hit_F), 32'(e.hit));
                chk("pred_taken_F", 32'(pred_taken_F), 32'(e.pt));
                chk("pred_target_F", pred_target_F, e.ptg);
                chk("flush_E", 32'(flush_E), 32'(e.fl));
            end
        end
    end

    // One cycle: drive, predict this cycle's outputs, then advance the model at the edge
    task automatic cyc(input logic st, input logic [1:0] pr, input logic v, input logic br,
                       input logic jp, input logic tk, input logic [31:0] pe,
                       input logic [31:0] te, input logic pte, input logic [31:0] pge);
        exp_t e;
        int unsigned fi, ei;
        bit act, hit, pt, fl;
        logic [31:0] ptg, nxt;
        stall_F = st; predict = pr; valid_E = v; branch_E = br; jump_E = jp;
        take_E = tk; pc_E = pe; target_E = te; pred_taken_E = pte; pred_target_E = pge;
        fi  = idx_of(m_pc);
        hit = m_v[fi] && (m_tag[fi] == tag_of(m_pc));
        pt  = hit && (m_j[fi] || pr[1]);
        ptg = hit ? m_tgt[fi] : 32'h0;
        act = jp || (br && tk);
        fl  = v && ((act != pte) || (act && pte && te != pge));
        e.pc = m_pc; e.hit = hit; e.pt = pt; e.ptg = ptg; e.fl = fl;
        q.push_back(e);
        if (fl)      nxt = act ? te : pe + 32'd4;
        else if (st) nxt = m_pc;
        else if (pt) nxt = ptg;
        else         nxt = m_pc + 32'd4;
        @(posedge clk);
        if (rst_n) begin
            m_pc = nxt;
            ei = idx_of(pe);
            if (v && act) begin
                m_v[ei] = 1; m_tag[ei] = tag_of(pe); m_tgt[ei] = te; m_j[ei] = jp;
            end else if (v && !br && !jp && pte) begin
                m_v[ei] = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [1:0] pr);
        cyc(1'b0, pr, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Redirect fetch to a: a not-taken branch at a-4 that was predicted taken
    task automatic goto(input logic [31:0] a);
        cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, a - 32'd4, 32'h0, 1'b1, 32'h0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        idle(2'b11);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
    endfunction

    initial begin
        rst_n = 1'b0;
        stall_F = 0; predict = 0; valid_E = 0; branch_E = 0; jump_E = 0; take_E = 0;
        pc_E = 0; target_E = 0; pred_taken_E = 0; pred_target_E = 0;
        for (int i = 0; i < ENT; i++) begin
            m_tag[i] = 0; m_tgt[i] = 0; m_j[i] = 0;
        end
        model_reset();
        @(posedge clk);
        #1;
        mon_en = 1;
        reset_pulse();
        for (int i = 0; i < 4; i++) idle(2'b11);
        cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h100, 1'b0, 32'h0);
        goto(32'h40);
        idle(2'b10);
        goto(32'h40);
        idle(2'b01);
        cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 1'b0, 32'h0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h200, 1'b0, 32'h0);
        goto(32'h80);
        idle(2'b00);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h440, 32'h0, 1'b1, 32'h0);
        goto(32'h40);
        idle(2'b11);
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h300, 1'b0, 32'h0);
        idle(2'b00);
        goto(32'hFFFF_FFFC);
        idle(2'b00);
        idle(2'b00);
        reset_pulse();
        idle(2'b11);
        goto(32'h80);
        idle(2'b00);
        for (int i = 0; i < 500; i++) begin
            int unsigned k;
            logic [31:0] te;
            if (i == 250) reset_pulse();
            k  = $urandom_range(0, 3);
            te = rnd_pc();
            cyc(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) != 0), 1'(k == 1 || k == 3), 1'(k == 2),
                1'($urandom_range(0, 1)), rnd_pc(), te, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? te : rnd_pc());
        end
        mon_en = 0;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d expected 0 entries", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
